byte_ram_ctrl: RTL and testbench
================================

Name: byte_ram_ctrl

Overview:
Sequencer and arbiter that shares one byte-wide RAM (ADDR_W-bit address, 8-bit write data, write-enable, combinational 8-bit read) between an instruction-fetch port and a data load/store port. It serialises 32-, 16- and 8-bit accesses into per-byte RAM cycles in little-endian order. It sign- or zero-extends load results, rejects misaligned data accesses, and returns one completion pulse per transaction. It sits between the CPU core and the byte RAM in the multi-cycle memory path.

Parameters:
ADDR_W, 10, RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
i_req  in  1  instruction fetch request (always 32-bit read)
i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored (forced to 0)
i_rdata  out  32  fetched word, valid when i_done=1, held until next i_done
i_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request
d_we  in  1  1=store, 0=load
d_size  in  2  00=byte, 01=half, 10=word, 11 treated as word
d_unsigned  in  1  1=zero-extend load, 0=sign-extend
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data; low bytes used for byte/half
d_rdata  out  32  load result, valid when d_done=1, held until next d_done
d_done  out  1  one-cycle completion pulse for data
d_err  out  1  misaligned flag, valid only with d_done
ram_addr  out  ADDR_W  RAM address
ram_d  out  8  RAM write data
ram_we  out  1  RAM write enable
ram_q  in  8  RAM combinational read data
busy  out  1  1 whenever state is not IDLE

Behaviour:
- States: IDLE, XFER, DONE. Reset forces IDLE; byte counter cnt=0; last_grant=DATA; i_rdata, d_rdata=0; i_done, d_done, d_err, ram_we, busy=0.
- IDLE: sample i_req and d_req. With one request, grant it. With both, grant the port not in last_grant (round-robin; first tie after reset goes to instruction). At grant, latch the port, base address, size, we, unsigned flag and wdata, then update last_grant. Requesters need not hold inputs after the grant cycle.
- Length n: byte=1, half=2, word=4.
- Misaligned data request (half with addr[0]=1; word with addr[1:0]≠0): go IDLE->DONE. No RAM cycle. d_err=1, d_rdata=0.
- XFER: one RAM byte per cycle. ram_addr = base+cnt. Store: ram_we=1, ram_d = wdata[8*cnt+7:8*cnt]. Load: ram_we=0; capture ram_q into byte lane cnt of the assembly register at the clock edge. At cnt=n-1, go to DONE; otherwise cnt++.
- DONE: assert the granted port's done for exactly one cycle. Result register updates on the same edge that enters DONE. Extension: byte from bit 7, half from bit 15, unless unsigned. Stores return d_rdata unchanged. Next state is IDLE.
- Latency: a request sampled in IDLE at cycle T gives done at T+1+n. A misaligned request gives done at T+1. A request still high in the IDLE cycle after done starts a new transaction.
- Outside XFER: ram_we=0, ram_addr=0, ram_d=0.
- Aligned accesses never cross the top of the address space.
- Reset mid-transaction: abort at that edge. ram_we is 0 from the next cycle; bytes already written stay written; no done pulse.

Test Plan:
1. d SW 0x11223344 @0x010, then LW @0x010 -> RAM[0x10..0x13]=44,33,22,11; each d_done exactly 5 cycles after grant cycle; d_rdata=0x11223344, d_err=0.
2. SB 0x80 @0x020; LB -> d_rdata=0xFFFFFF80; LBU -> 0x00000080; SH 0xFFFE @0x022, LH -> 0xFFFFFFFE, LHU -> 0x0000FFFE; each d_done at T+2 (byte) or T+3 (half).
3. i_req and d_req both high from reset, held -> grants alternate I, D, I, D; no port starved; never both done in one cycle.
4. SH @0x013 and LW @0x012 -> d_done at T+1 with d_err=1, d_rdata=0, ram_we never asserted.
5. Fetch with i_addr=0x013 over RAM[0x10..0x13]=0x13,0x00,0x05,0x93 -> i_rdata=0x93050013 at T+5.
6. SW 0xAABBCCDD @0x040 with rst pulsed in 2nd XFER cycle -> only RAM[0x40]=DD, RAM[0x41]=CC written; no d_done; busy=0 and ram_we=0 the cycle after reset.

Source files
------------

// File: rtl/byte_ram_ctrl.sv
// byte_ram_ctrl: shares one byte-wide RAM between a fetch port and a data
// port, serialising word/half/byte accesses into little-endian byte cycles.
// Ports: clk, rst (sync, active-high)
//   fetch : i_req, i_addr -> i_rdata, i_done
//   data  : d_req, d_we, d_size, d_unsigned, d_addr, d_wdata
//           -> d_rdata, d_done, d_err
//   ram   : ram_addr, ram_d, ram_we <- ram_q (combinational read)
//   busy  : high whenever the sequencer is not idle
module byte_ram_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_d,
    output logic              ram_we,
    input  logic [7:0]        ram_q,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t state, state_nx;

    logic [1:0]        cnt;
    logic [1:0]        last;
    logic              last_d;
    logic              g_d;
    logic [ADDR_W-1:0] base;
    logic              we_r;
    logic              uns_r;
    logic              err_r;
    logic [31:0]       wdata_r;
    logic [31:0]       asm_r;

    logic              gnt_i;
    logic              gnt_d;
    logic              mis_d;
    logic [1:0]        d_last;
    logic [31:0]       word_c;
    logic [31:0]       ext_c;
    logic [7:0]        wbyte;
    logic              unused_bits;

    assign unused_bits = ^i_addr[1:0];

    // Round-robin: on a tie, serve the port that was not served last.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
                gnt_i = last_d;
                gnt_d = !last_d;
            end else begin
                gnt_i = i_req;
                gnt_d = d_req;
            end
        end
    end

    // d_last is length-1; its set bits are exactly the address bits
    // that must be zero for an aligned access.
    always_comb begin
        unique case (d_size)
            2'b00:   d_last = 2'd0;
            2'b01:   d_last = 2'd1;
            default: d_last = 2'd3;
        endcase
        mis_d = (d_last[0] & d_addr[0]) | (d_last[1] & d_addr[1]);
    end

    // Load word as it will look once the current byte lands.
    always_comb begin
        word_c = asm_r;
        unique case (cnt)
            2'd0: word_c[7:0]   = ram_q;
            2'd1: word_c[15:8]  = ram_q;
            2'd2: word_c[23:16] = ram_q;
            default: word_c[31:24] = ram_q;
        endcase
        unique case (last)
            2'd0:    ext_c = {{24{!uns_r & word_c[7]}}, word_c[7:0]};
            2'd1:    ext_c = {{16{!uns_r & word_c[15]}}, word_c[15:0]};
            default: ext_c = word_c;
        endcase
    end

    always_comb begin
        unique case (cnt)
            2'd0: wbyte = wdata_r[7:0];
            2'd1: wbyte = wdata_r[15:8];
            2'd2: wbyte = wdata_r[23:16];
            default: wbyte = wdata_r[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (gnt_d && mis_d)      state_nx = DONE;
                else if (gnt_i || gnt_d) state_nx = XFER;
            end
            XFER:    if (cnt == last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            last    <= '0;
            last_d  <= 1'b1;
            g_d     <= 1'b0;
            base    <= '0;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= '0;
            asm_r   <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (gnt_i) begin
                g_d    <= 1'b0;
                last_d <= 1'b0;
                base   <= {i_addr[ADDR_W-1:2], 2'b00};
                last   <= 2'd3;
                we_r   <= 1'b0;
                uns_r  <= 1'b1;
                err_r  <= 1'b0;
                cnt    <= '0;
            end else if (gnt_d) begin
                g_d     <= 1'b1;
                last_d  <= 1'b1;
                base    <= d_addr;
                last    <= d_last;
                we_r    <= d_we;
                uns_r   <= d_unsigned;
                wdata_r <= d_wdata;
                err_r   <= mis_d;
                cnt     <= '0;
                if (mis_d) d_rdata <= '0;
            end
            if (state == XFER) begin
                asm_r <= word_c;
                if (cnt == last) begin
                    if (!g_d)      i_rdata <= word_c;
                    else if (!we_r) d_rdata <= ext_c;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (state == XFER) begin
            ram_addr = base + ADDR_W'(cnt);
            ram_we   = we_r;
            if (we_r) ram_d = wbyte;
        end
        i_done = (state == DONE) && !g_d;
        d_done = (state == DONE) && g_d;
        d_err  = (state == DONE) && g_d && err_r;
        busy   = (state != IDLE);
    end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// tb_byte_ram_ctrl: directed bench for byte_ram_ctrl with a byte RAM model
// and a queue of expected completions.
module tb_byte_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [9:0]  i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        busy;

    byte_ram_ctrl #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .d_err      (d_err),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .busy       (busy)
    );

    typedef struct {
        string       tag;
        bit          port;
        bit [31:0]   rdata;
        bit          err;
        int          lat;
        int          nwe;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0;
    int both_cnt = 0;
    logic mem_clr;
    logic [7:0] mem [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int j = 0; j < 1024; j++) mem[j] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_d;
        end
    end

    assign ram_q = mem[ram_addr];

    always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;
    always @(negedge clk) if (i_done && d_done) both_cnt <= both_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic d_op(input bit we, input bit [1:0] sz, input bit uns,
                        input bit [9:0] addr, input bit [31:0] wd,
                        input bit [31:0] er, input bit ee,
                        input string tag);
        int   k;
        int   n;
        int   w0;
        exp_t e;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        d_req      = 1'b1;
        d_we       = we;
        d_size     = sz;
        d_unsigned = uns;
        d_addr     = addr;
        d_wdata    = wd;
        sb.push_back('{tag: tag, port: 1'b1, rdata: er, err: ee,
                       lat: ee ? 1 : n + 1,
                       nwe: (!ee && we) ? n : 0});
        w0 = we_cnt;
        @(posedge clk);
        @(negedge clk);
        d_req      = 1'b0;
        d_we       = 1'($urandom);
        d_size     = 2'($urandom);
        d_unsigned = 1'($urandom);
        d_addr     = 10'($urandom);
        d_wdata    = $urandom;
        k = 1;
        while (!d_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk({e.tag, " done"}, 32'(d_done), 32'd1);
        chk({e.tag, " lat"}, k, e.lat);
        chk({e.tag, " rdata"}, d_rdata, e.rdata);
        chk({e.tag, " err"}, 32'(d_err), 32'(e.err));
        chk({e.tag, " i_done"}, 32'(i_done), 32'd0);
        @(negedge clk);
        chk({e.tag, " pulse"}, 32'(d_done), 32'd0);
        chk({e.tag, " busy"}, 32'(busy), 32'd0);
        chk({e.tag, " writes"}, we_cnt - w0, e.nwe);
    endtask

    task automatic f_op(input bit [9:0] addr, input bit [31:0] er,
                        input string tag);
        int   k;
        exp_t e;
        i_req  = 1'b1;
        i_addr = addr;
        sb.push_back('{tag: tag, port: 1'b0, rdata: er, err: 1'b0,
                       lat: 5, nwe: 0});
        @(posedge clk);
        @(negedge clk);
        i_req  = 1'b0;
        i_addr = 10'($urandom);
        k = 1;
        while (!i_done && k < 20) begin
            @(negedge clk);
            k++;
        end
        e = sb.pop_front();
        chk({e.tag, " done"}, 32'(i_done), 32'd1);
        chk({e.tag, " lat"}, k, e.lat);
        chk({e.tag, " rdata"}, i_rdata, e.rdata);
        chk({e.tag, " d_done"}, 32'(d_done), 32'd0);
        @(negedge clk);
        chk({e.tag, " pulse"}, 32'(i_done), 32'd0);
        chk({e.tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   cyc;
        int   got;
        int   prev;
        int   dn;
        exp_t e;

        rst        = 1'b1;
        mem_clr    = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_size     = '0;
        d_unsigned = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst i_done", 32'(i_done), 32'd0);
        chk("rst d_done", 32'(d_done), 32'd0);
        chk("rst d_err", 32'(d_err), 32'd0);
        chk("rst ram_we", 32'(ram_we), 32'd0);
        chk("rst ram_addr", 32'(ram_addr), 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        d_op(1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 32'h0, 1'b0, "sw");
        chk("mem10", 32'(mem[10'h010]), 32'h44);
        chk("mem11", 32'(mem[10'h011]), 32'h33);
        chk("mem12", 32'(mem[10'h012]), 32'h22);
        chk("mem13", 32'(mem[10'h013]), 32'h11);
        d_op(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h11223344, 1'b0, "lw");

        d_op(1'b1, 2'b00, 1'b0, 10'h020, 32'h5A5A5A80, 32'h11223344, 1'b0, "sb");
        d_op(1'b0, 2'b00, 1'b0, 10'h020, 32'h0, 32'hFFFFFF80, 1'b0, "lb");
        d_op(1'b0, 2'b00, 1'b1, 10'h020, 32'h0, 32'h00000080, 1'b0, "lbu");
        d_op(1'b1, 2'b01, 1'b0, 10'h022, 32'h1234FFFE, 32'h00000080, 1'b0, "sh");
        d_op(1'b0, 2'b01, 1'b0, 10'h022, 32'h0, 32'hFFFFFFFE, 1'b0, "lh");
        d_op(1'b0, 2'b01, 1'b1, 10'h022, 32'h0, 32'h0000FFFE, 1'b0, "lhu");
        d_op(1'b0, 2'b11, 1'b0, 10'h020, 32'h0, 32'hFFFE0080, 1'b0, "lw sz3");

        d_op(1'b1, 2'b10, 1'b0, 10'h010, 32'h93050013, 32'hFFFE0080, 1'b0, "sw2");
        f_op(10'h013, 32'h93050013, "fetch");

        d_op(1'b1, 2'b01, 1'b0, 10'h013, 32'hDEADBEEF, 32'h0, 1'b1, "sh mis");
        d_op(1'b0, 2'b10, 1'b0, 10'h012, 32'h0, 32'h0, 1'b1, "lw mis");
        chk("mis mem13", 32'(mem[10'h013]), 32'h93);

        d_req   = 1'b1;
        d_we    = 1'b1;
        d_size  = 2'b10;
        d_addr  = 10'h040;
        d_wdata = 32'hAABBCCDD;
        @(posedge clk);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort ram_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        dn = 32'(d_done);
        repeat (6) begin
            @(negedge clk);
            dn += 32'(d_done);
        end
        chk("abort no done", dn, 0);
        chk("abort mem40", 32'(mem[10'h040]), 32'hDD);
        chk("abort mem41", 32'(mem[10'h041]), 32'hCC);
        chk("abort mem42", 32'(mem[10'h042]), 32'h00);
        chk("abort mem43", 32'(mem[10'h043]), 32'h00);

        rst        = 1'b1;
        i_req      = 1'b1;
        i_addr     = 10'h010;
        d_req      = 1'b1;
        d_we       = 1'b0;
        d_size     = 2'b00;
        d_unsigned = 1'b1;
        d_addr     = 10'h020;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            sb.push_back('{tag: "arb", port: 1'(j % 2),
                           rdata: (j % 2) ? 32'h00000080 : 32'h93050013,
                           err: 1'b0,
                           lat: (j == 0) ? 5 : (j % 2) ? 3 : 6,
                           nwe: 0});
        end
        cyc  = 0;
        got  = 0;
        prev = 0;
        while (got < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (i_done || d_done) begin
                e = sb.pop_front();
                got++;
                chk("arb port", 32'(d_done), 32'(e.port));
                chk("arb gap", cyc - prev, e.lat);
                chk("arb data", e.port ? d_rdata : i_rdata, e.rdata);
                prev = cyc;
            end
        end
        chk("arb count", got, 6);
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (8) @(negedge clk);
        chk("never both done", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
